// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
//   - Legacy 2-bit state encodings, kept so existing code can still compare
//     against them, plus the state enum built from those same values.
//   - bit_cycles(): bit period in clk cycles (integer CLK_FREQ/BAUD_RATE).
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   restart  : realign the period; the next tick comes BIT_CYCLES cycles later
//   bit_tick : high for one cycle at the end of every BIT_CYCLES-cycle period
module uart_baud_gen #(
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == CNT_W'(BIT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits (LSB first), STOP_BITS
// stop bits, each bit held CLK_FREQ/BAUD_RATE clk cycles.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   data_in : byte to send, captured on acceptance (valid && ready)
//   valid   : send request; ignored while ready is low
//   ready   : high in IDLE when a new byte can be accepted
//   tx      : registered serial line, idle high
//   done    : one-cycle pulse on the first IDLE cycle after a frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  done
);

  localparam int unsigned T     = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

  generate
    if (T < 2) begin : g_bad_period
      $error("uart_tx: bit period CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_cnt;
  logic                  bit_tick;
  logic                  accept;

  // ready is only ever high in IDLE, so acceptance implies IDLE.
  assign accept     = valid && ready;
  assign shift_next = shift_q >> 1;

  // Restarting at acceptance makes the first tick land exactly T cycles
  // after the start bit appears on the line.
  uart_baud_gen #(
    .BIT_CYCLES (T)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (accept),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      ready    <= 1'b0;
      done     <= 1'b0;
      shift_q  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also raises ready on the first edge after reset release.
          ready <= !accept;
          if (accept) begin
            shift_q  <= data_in;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            tx    <= shift_q[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_next[0];
              shift_q <= shift_next;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              done  <= 1'b1;
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, data_in1;
  logic       valid, valid1;
  logic       ready, tx, done;
  logic       ready1, tx1, done1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid),
    .ready(ready), .tx(tx), .done(done));

  uart_tx #(.DATA_WIDTH(8), .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .valid(valid1),
    .ready(ready1), .tx(tx1), .done(done1));

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level c cycles after the start bit begins (T=10).
  function automatic logic exp_line(input logic [7:0] b, input int c);
    if (c < 10) return 1'b0;
    if (c < 90) return b[(c - 10) / 10];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0; valid = 1'b0; valid1 = 1'b0; data_in = '0; data_in1 = '0;
    #1 rst = 1'b1;
    #1;
    compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx got=%b want=1", tx); end
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%b want=0", ready); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got=%b want=0", done); end
    tick(); tick();
    rst = 1'b0;
    #1;
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready_pre_edge got=%b want=0", ready); end
    tick();
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_first_edge got=%b want=1", ready); end
    compared++; if (ready1 !== 1'b1) begin mismatched++; $display("FAIL reset_ready1_first_edge got=%b want=1", ready1); end
    compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx_idle got=%b want=1", tx); end
  endtask

  // 0xA5 frame; data_in is scrambled after acceptance and must not matter.
  task automatic test_single_frame();
    data_in = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0; data_in = 8'h00;
    for (int c = 0; c < 110; c++) begin
      compared++; if (tx !== exp_line(8'hA5, c)) begin mismatched++; $display("FAIL a5_tx cycle=%0d got=%b want=%b", c, tx, exp_line(8'hA5, c)); end
      compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL a5_done_early cycle=%0d got=%b want=0", c, done); end
      tick();
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL a5_done_at_110 got=%b want=1", done); end
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL a5_ready_at_110 got=%b want=1", ready); end
    compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL a5_tx_idle got=%b want=1", tx); end
    tick();
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL a5_done_width got=%b want=0", done); end
  endtask

  task automatic test_back_to_back();
    data_in = 8'h00; valid = 1'b1;
    tick();
    data_in = 8'hFF;
    for (int c = 0; c < 110; c++) begin
      compared++; if (tx !== exp_line(8'h00, c)) begin mismatched++; $display("FAIL b2b0_tx cycle=%0d got=%b want=%b", c, tx, exp_line(8'h00, c)); end
      compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b0_ready cycle=%0d got=%b want=0", c, ready); end
      tick();
    end
    compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL b2b_gap_tx got=%b want=1", tx); end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL b2b_gap_done got=%b want=1", done); end
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL b2b_gap_ready got=%b want=1", ready); end
    tick();
    valid = 1'b0;
    for (int c = 0; c < 110; c++) begin
      compared++; if (tx !== exp_line(8'hFF, c)) begin mismatched++; $display("FAIL b2b1_tx cycle=%0d got=%b want=%b", c, tx, exp_line(8'hFF, c)); end
      compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL b2b1_ready cycle=%0d got=%b want=0", c, ready); end
      tick();
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL b2b1_done got=%b want=1", done); end
    for (int c = 0; c < 15; c++) begin
      tick();
      compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL b2b_no_third cycle=%0d got=%b want=1", c, tx); end
    end
  endtask

  task automatic test_ignore_busy();
    data_in = 8'h96; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 110; c++) begin
      if (c == 30) begin data_in = 8'h3C; valid = 1'b1; end
      if (c == 31) valid = 1'b0;
      compared++; if (tx !== exp_line(8'h96, c)) begin mismatched++; $display("FAIL busy_tx cycle=%0d got=%b want=%b", c, tx, exp_line(8'h96, c)); end
      tick();
    end
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL busy_done got=%b want=1", done); end
    for (int c = 0; c < 20; c++) begin
      tick();
      compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL busy_no_extra cycle=%0d got=%b want=1", c, tx); end
      compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL busy_ready_after cycle=%0d got=%b want=1", c, ready); end
    end
  endtask

  task automatic test_reset_mid_frame();
    data_in = 8'h00; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    compared++; if (tx !== 1'b0) begin mismatched++; $display("FAIL midrst_tx_before got=%b want=0", tx); end
    rst = 1'b1;
    #1;
    compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL midrst_tx_async got=%b want=1", tx); end
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL midrst_ready got=%b want=0", ready); end
    tick(); tick();
    rst = 1'b0;
    #1;
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL midrst_ready_pre_edge got=%b want=0", ready); end
    tick();
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL midrst_ready_first_edge got=%b want=1", ready); end
    for (int c = 0; c < 120; c++) begin
      compared++; if (done !== 1'b0 || tx !== 1'b1) begin mismatched++; $display("FAIL midrst_quiet cycle=%0d done=%b tx=%b want done=0 tx=1", c, done, tx); end
      tick();
    end
  endtask

  // Bench-side receiver: detect the start edge, sample mid-bit.
  task automatic test_loopback();
    logic [7:0] bytes [4];
    bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hAA; bytes[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] rx_byte;
      int rx_start, off, rx_done, w;
      rx_byte = '0; rx_start = -1; rx_done = 0; w = 0;
      while (ready !== 1'b1 && w < 200) begin tick(); w++; end
      compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL loop_ready_timeout byte=%0d got=%b want=1", i, ready); end
      data_in = bytes[i]; valid = 1'b1;
      tick();
      valid = 1'b0;
      for (int k = 0; k < 130; k++) begin
        if (rx_start < 0) begin
          if (tx === 1'b0) rx_start = k;
        end else begin
          off = k - rx_start;
          if (off >= 15 && off < 95 && ((off - 15) % 10) == 0) rx_byte[(off - 15) / 10] = tx;
          if (off == 95 || off == 105) begin
            compared++; if (tx !== 1'b1) begin mismatched++; $display("FAIL loop_stop byte=%0d off=%0d got=%b want=1", i, off, tx); end
          end
        end
        if (done === 1'b1) rx_done++;
        tick();
      end
      compared++; if (rx_start != 0) begin mismatched++; $display("FAIL loop_start byte=%0d got=%0d want=0", i, rx_start); end
      compared++; if (rx_byte !== bytes[i]) begin mismatched++; $display("FAIL loop_data got=%h want=%h", rx_byte, bytes[i]); end
      compared++; if (rx_done != 1) begin mismatched++; $display("FAIL loop_done byte=%0d got=%0d want=1", i, rx_done); end
    end
  endtask

  task automatic test_one_stop_bit();
    data_in1 = 8'h81; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      compared++; if (tx1 !== exp_line(8'h81, c)) begin mismatched++; $display("FAIL stop1_tx cycle=%0d got=%b want=%b", c, tx1, exp_line(8'h81, c)); end
      compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL stop1_done_early cycle=%0d got=%b want=0", c, done1); end
      tick();
    end
    compared++; if (done1 !== 1'b1) begin mismatched++; $display("FAIL stop1_done_at_100 got=%b want=1", done1); end
    compared++; if (ready1 !== 1'b1) begin mismatched++; $display("FAIL stop1_ready got=%b want=1", ready1); end
    tick();
    compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL stop1_done_width got=%b want=0", done1); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_loopback();
    test_one_stop_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 115200, line bit rate.
REQ-004 Parameter STOP_BITS, default 2, stop bits per frame; legal values 1 or 2.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  DATA_WIDTH  byte to transmit; sampled only on acceptance.
REQ-008 valid  input  1  request to send data_in.
REQ-009 ready  output  1  high when a new byte can be accepted.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 Bit period T SHALL be the integer CLK_FREQ/BAUD_RATE clk cycles; each line bit SHALL be held exactly T cycles (868 with defaults).
REQ-013 States SHALL be IDLE, START, DATA, STOP; encoding comes from the package.
REQ-014 Acceptance SHALL occur on a cycle with valid=1 and ready=1; data_in SHALL be latched into a shift register on that edge.
REQ-015 ready SHALL be 1 only in IDLE; valid while ready=0 SHALL be ignored with no queuing.
REQ-016 On acceptance: IDLE->START; tx SHALL drive 0 from the next cycle for T cycles.
REQ-017 START->DATA after T cycles; data bits SHALL be sent LSB first, DATA_WIDTH bits, each T cycles.
REQ-018 DATA->STOP after the last data bit; tx SHALL be 1 for STOP_BITS*T cycles.
REQ-019 STOP->IDLE after the last stop cycle; done SHALL be 1 for exactly the first IDLE cycle.
REQ-020 Frame length from first start-bit cycle to last stop-bit cycle SHALL be (1+DATA_WIDTH+STOP_BITS)*T cycles (9548 with defaults).
REQ-021 Back-to-back: valid high during the done cycle SHALL be accepted that cycle; exactly one idle-high cycle SHALL separate frames.
REQ-022 tx SHALL be registered, glitch-free, and 1 in IDLE.
REQ-023 Changes on data_in after acceptance SHALL NOT affect the frame in flight.
REQ-024 The bit counter SHALL be sized $clog2(T) bits; the bit index SHALL be sized $clog2(DATA_WIDTH+1) bits; neither SHALL wrap within a frame.

Reset
REQ-025 rst=1 SHALL immediately, without a clock, force state=IDLE, tx=1, ready=0, done=0, and clear counters and the shift register.
REQ-026 ready SHALL rise on the first clk edge after rst deasserts.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; the line returns high at once.

Structure
REQ-028 Package uart_pkg SHALL hold the state typedef/encoding and the function computing T from CLK_FREQ and BAUD_RATE; it is shared with the receiver.
REQ-029 One sub-module uart_baud_gen SHALL produce a single-cycle bit_tick every T cycles, restartable by uart_tx at acceptance.
REQ-030 Elaboration SHALL fail when T<2 or when STOP_BITS is not 1 or 2.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so T=10)
REQ-031 Send 0xA5 -> tx low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, high 20 cycles; done pulses once 110 cycles after the start bit begins.
REQ-032 valid held high with 0x00 then 0xFF -> two frames with exactly one idle cycle between them; ready=0 throughout each frame.
REQ-033 Pulse valid with 0x3C mid-frame -> ignored; the current frame is unchanged and no extra frame is sent.
REQ-034 Assert rst at cycle 40 of a frame -> tx=1 in the same cycle, no done pulse, ready=1 on the first edge after release.
REQ-035 Loopback with the receiver (same parameters), bytes 0x00, 0x55, 0xAA, 0xFF -> each received result matches and one receiver done per byte.
REQ-036 STOP_BITS=1 with 0x81 -> frame length 100 cycles and done after one stop period.
